column_scheduler: RTL and testbench

COLUMN_SCHEDULER -- requirements
Module: column_scheduler

---
 rtl/column_scheduler_pkg.sv | 16 +
 rtl/column_scheduler_rr_pick.sv | 28 ++
 rtl/column_scheduler.sv | 145 ++++++++++++++
 tb/tb_column_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_scheduler_pkg.sv
// Shared encodings for the column scheduler: FSM states, packet marker codes
// and the bit position that flags an end-of-packet marker in a cell word.
package column_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [9:0] CODE_EOP = 10'h100;
    localparam logic [9:0] CODE_EEP = 10'h101;
    localparam int         MARK_BIT = 8;

endpackage

// File: rtl/column_scheduler_rr_pick.sv
// Round-robin picker: first requesting line at or after ptr_i, wrapping modulo N.
// Purely combinational; vld_o low when no line requests.
module rr_pick #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [AW-1:0] ptr_i,
    output logic [AW-1:0] gnt_o,
    output logic          vld_o
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[idx]) begin
                gnt_o = AW'(idx);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/column_scheduler.sv
// Moves whole packets from one column's cells to the port Tx FIFO; request to first write 2 cycles, then 1 word/cycle.
// Stalls (no read/write) while tx_full_i is high; a starved packet is closed with EEP after TMO idle cycles and the rest flushed.
module column_scheduler
    import column_scheduler_pkg::*;
#(
    parameter int PORTNUM = 16,
    parameter int AW      = 4,
    parameter int BW      = 10,
    parameter int TMO     = 255
) (
    input  logic               gclk,
    input  logic               reset,
    input  logic [PORTNUM-1:0] cell_empty_i,
    input  logic [BW-1:0]      head_i,
    input  logic               tx_full_i,
    output logic [AW-1:0]      sel_o,
    output logic               ld_sel_o,
    output logic [PORTNUM-1:0] rd_en_o,
    output logic               tx_wr_o,
    output logic [BW-1:0]      tx_data_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int            SW        = $clog2(TMO + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(TMO);

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     sel_q, sel_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              run_q, run_d;

    logic [PORTNUM-1:0] req;
    logic [AW-1:0]      pick_idx;
    logic               pick_vld;
    logic               cell_rdy;
    logic               mark;
    logic               tmo_hit;
    logic               xfer_go;
    logic               rd_hit;
    logic [AW-1:0]      sel_inc;

    assign req      = ~cell_empty_i;
    assign cell_rdy = ~cell_empty_i[sel_q];
    assign mark     = head_i[MARK_BIT];
    assign tmo_hit  = (state_q == ST_XFER) && !tx_full_i && (stall_q == STALL_MAX);
    assign xfer_go  = (state_q == ST_XFER) && !tx_full_i && !tmo_hit && cell_rdy;
    assign sel_inc  = (sel_q == AW'(PORTNUM - 1)) ? '0 : sel_q + AW'(1);

    rr_pick #(
        .N  (PORTNUM),
        .AW (AW)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_idx),
        .vld_o (pick_vld)
    );

    // run_q holds off arbitration until the first edge after reset release.
    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            stall_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            stall_q <= stall_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        stall_d = '0;
        run_d   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (run_q && pick_vld) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: state_d = ST_XFER;
            ST_XFER: begin
                stall_d = stall_q;
                if (tmo_hit) begin
                    stall_d = '0;
                    state_d = ST_FLUSH;
                end else if (xfer_go) begin
                    stall_d = '0;
                    if (mark) begin
                        ptr_d   = sel_inc;
                        state_d = ST_IDLE;
                    end
                end else if (!tx_full_i) begin
                    stall_d = stall_q + SW'(1);
                end
            end
            ST_FLUSH: begin
                if (cell_rdy && mark) begin
                    ptr_d   = sel_inc;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_sel_o  = 1'b0;
        rd_hit    = 1'b0;
        tx_wr_o   = 1'b0;
        tx_data_o = '0;
        err_o     = 1'b0;
        case (state_q)
            ST_IDLE: ld_sel_o = run_q && pick_vld;
            ST_XFER: begin
                if (tmo_hit) begin
                    tx_wr_o   = 1'b1;
                    tx_data_o = BW'(CODE_EEP);
                    err_o     = 1'b1;
                end else if (xfer_go) begin
                    rd_hit    = 1'b1;
                    tx_wr_o   = 1'b1;
                    tx_data_o = head_i;
                end
            end
            ST_FLUSH: rd_hit = cell_rdy;
            default: ;
        endcase
    end

    assign rd_en_o = rd_hit ? (PORTNUM'(1) << sel_q) : '0;
    assign sel_o   = sel_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_column_scheduler.sv
// Bench for column_scheduler: cell memory modelled as per-line queues, scoreboard of expected Tx words and grants.
module tb_column_scheduler;
    import column_scheduler_pkg::*;

    localparam int N = 16;

    logic          gclk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  cell_empty_i;
    logic [9:0]    head_i;
    logic          tx_full_i;
    logic [3:0]    sel_o;
    logic          ld_sel_o;
    logic [N-1:0]  rd_en_o;
    logic          tx_wr_o;
    logic [9:0]    tx_data_o;
    logic          busy_o;
    logic          err_o;

    column_scheduler #(.PORTNUM(N), .AW(4), .BW(10), .TMO(4)) dut (
        .gclk         (gclk),
        .reset        (reset),
        .cell_empty_i (cell_empty_i),
        .head_i       (head_i),
        .tx_full_i    (tx_full_i),
        .sel_o        (sel_o),
        .ld_sel_o     (ld_sel_o),
        .rd_en_o      (rd_en_o),
        .tx_wr_o      (tx_wr_o),
        .tx_data_o    (tx_data_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 gclk = ~gclk;

    logic [9:0] cellq [N][$];
    logic [9:0] exp_q[$];
    logic [3:0] exp_sel_q[$];
    logic [3:0] exp_sel;
    bit         ld_pending;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    int ld_cyc = 0, first_wr_cyc = -1, last_wr_cyc = 0, prev_wr_cyc = 0;
    logic s_wr, s_err, s_busy, s_ld;
    logic [N-1:0] s_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) cell_empty_i[i] = (cellq[i].size() == 0);
        head_i = (cellq[sel_o].size() != 0) ? cellq[sel_o][0] : 10'h000;
    endtask

    function automatic bit cells_empty();
        for (int i = 0; i < N; i++) if (cellq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Words base, base+1, ... with the last one replaced by EOP when eop is set.
    task automatic load_pkt(input int line, input int nw, input logic [9:0] base,
                            input bit eop, input bit expect_out);
        logic [9:0] w;
        for (int k = 0; k < nw; k++) begin
            w = (eop && k == nw - 1) ? CODE_EOP : base + 10'(k);
            cellq[line].push_back(w);
            if (expect_out) exp_q.push_back(w);
        end
        refresh();
    endtask

    task automatic tick();
        bit       pop;
        int       pop_line;
        pop = 1'b0;
        pop_line = 0;
        @(negedge gclk);
        cyc++;
        s_wr = tx_wr_o; s_rd = rd_en_o; s_err = err_o; s_busy = busy_o; s_ld = ld_sel_o;
        if (ld_pending) begin
            chk("grant_sel", sel_o, exp_sel);
            ld_pending = 1'b0;
        end
        if (ld_sel_o) begin
            ld_cyc = cyc;
            if (exp_sel_q.size() == 0) chk("ld_extra", exp_sel_q.size(), 1);
            else begin
                exp_sel = exp_sel_q.pop_front();
                ld_pending = 1'b1;
            end
        end
        if (tx_wr_o) begin
            wr_cnt++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) chk("tx_extra", exp_q.size(), 1);
            else chk("tx_data", tx_data_o, exp_q.pop_front());
        end else begin
            chk("tx_data_idle", tx_data_o, 0);
        end
        if (rd_en_o != 0) begin
            rd_cnt++;
            chk("rd_onehot", rd_en_o, N'(1) << sel_o);
            chk("rd_nonempty", cellq[sel_o].size() != 0, 1);
            pop = 1'b1;
            pop_line = int'(sel_o);
        end
        if (err_o) begin
            err_cnt++;
            chk("err_eep", {tx_wr_o, tx_data_o}, {1'b1, CODE_EEP});
        end
        @(posedge gclk);
        #1;
        if (pop && cellq[pop_line].size() != 0) void'(cellq[pop_line].pop_front());
        refresh();
    endtask

    task automatic drain(input string tag, input int max);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
            done = (exp_q.size() == 0) && (exp_sel_q.size() == 0) && !ld_pending &&
                   !s_busy && cells_empty();
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic wait_writes(input string tag, input int target, input int max);
        int n;
        n = 0;
        while (wr_cnt < target && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, wr_cnt >= target, 1);
    endtask

    initial begin
        int snap;
        tx_full_i = 1'b0;
        ld_pending = 1'b0;
        refresh();
        tick();
        tick();
        chk("rst_busy", s_busy, 0);
        chk("rst_ld", s_ld, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_wr", s_wr, 0);
        reset = 1'b1;
        tick();

        // Single packet on line 3
        wr_cnt = 0; first_wr_cyc = -1;
        exp_sel_q.push_back(4'd3);
        load_pkt(3, 4, 10'h011, 1'b1, 1'b1);
        drain("single", 60);
        chk("single_latency", first_wr_cyc - ld_cyc, 2);
        chk("single_burst", last_wr_cyc - first_wr_cyc, 3);
        chk("single_words", wr_cnt, 4);

        // ptr now 4: line 5 beats line 3
        exp_sel_q.push_back(4'd5); exp_sel_q.push_back(4'd3);
        load_pkt(5, 2, 10'h021, 1'b1, 1'b1);
        load_pkt(3, 2, 10'h031, 1'b1, 1'b1);
        drain("ptr4", 60);

        // Line 5 alone moves ptr to 6, then round-robin 15, 0, 5
        exp_sel_q.push_back(4'd5);
        load_pkt(5, 2, 10'h041, 1'b1, 1'b1);
        drain("to_ptr6", 40);
        exp_sel_q.push_back(4'd15); exp_sel_q.push_back(4'd0); exp_sel_q.push_back(4'd5);
        load_pkt(15, 1, 10'h051, 1'b1, 1'b1);
        load_pkt(0, 1, 10'h061, 1'b1, 1'b1);
        load_pkt(5, 1, 10'h071, 1'b1, 1'b1);
        drain("rr", 60);

        // Wrap: ptr 15 via line 14, then line 15, then ptr 0 picks 1 before 15
        exp_sel_q.push_back(4'd14);
        load_pkt(14, 2, 10'h0E1, 1'b1, 1'b1);
        drain("to_ptr15", 40);
        exp_sel_q.push_back(4'd15);
        load_pkt(15, 2, 10'h0F1, 1'b1, 1'b1);
        drain("wrap", 40);
        exp_sel_q.push_back(4'd1); exp_sel_q.push_back(4'd15);
        load_pkt(1, 2, 10'h011, 1'b1, 1'b1);
        load_pkt(15, 2, 10'h0F5, 1'b1, 1'b1);
        drain("wrap_ptr0", 60);

        // Back-pressure mid-packet
        err_cnt = 0;
        snap = wr_cnt;
        exp_sel_q.push_back(4'd7);
        load_pkt(7, 5, 10'h081, 1'b1, 1'b1);
        wait_writes("bp", snap + 2, 20);
        tx_full_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_wr", s_wr, 0);
            chk("bp_rd", s_rd, 0);
        end
        tx_full_i = 1'b0;
        drain("bp", 40);
        chk("bp_err", err_cnt, 0);
        chk("bp_words", wr_cnt - snap, 5);

        // Timeout: line 9 starves after two words
        err_cnt = 0;
        exp_sel_q.push_back(4'd9);
        load_pkt(9, 2, 10'h0A1, 1'b0, 1'b1);
        exp_q.push_back(CODE_EEP);
        begin
            int n;
            n = 0;
            while (err_cnt == 0 && n < 40) begin
                tick();
                n++;
            end
        end
        chk("tmo_err", err_cnt, 1);
        chk("tmo_gap", last_wr_cyc - prev_wr_cyc, 5);
        tick();
        chk("tmo_flush_busy", s_busy, 1);
        rd_cnt = 0;
        snap = wr_cnt;
        load_pkt(9, 2, 10'h0B1, 1'b1, 1'b0);
        drain("flush", 40);
        chk("flush_rd", rd_cnt, 2);
        chk("flush_wr", wr_cnt - snap, 0);
        chk("flush_err_once", err_cnt, 1);

        // After flush ptr is 10: line 11 before line 9
        exp_sel_q.push_back(4'd11); exp_sel_q.push_back(4'd9);
        load_pkt(11, 1, 10'h0C1, 1'b1, 1'b1);
        load_pkt(9, 1, 10'h0C5, 1'b1, 1'b1);
        drain("ptr10", 60);

        // Reset in the middle of a packet
        snap = wr_cnt;
        exp_sel_q.push_back(4'd4);
        load_pkt(4, 6, 10'h0D1, 1'b1, 1'b1);
        wait_writes("rstmid", snap + 2, 20);
        reset = 1'b0;
        #1;
        chk("rstmid_wr", tx_wr_o, 0);
        chk("rstmid_rd", rd_en_o, 0);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_sel", sel_o, 0);
        chk("rstmid_data", tx_data_o, 0);
        chk("rstmid_err", err_o, 0);
        chk("rstmid_ld", ld_sel_o, 0);
        for (int i = 0; i < N; i++) cellq[i].delete();
        exp_q.delete();
        exp_sel_q.delete();
        ld_pending = 1'b0;
        load_pkt(1, 2, 10'h031, 1'b1, 1'b1);
        load_pkt(12, 2, 10'h035, 1'b1, 1'b1);
        exp_sel_q.push_back(4'd1); exp_sel_q.push_back(4'd12);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rsthold_ld", s_ld, 0);
            chk("rsthold_busy", s_busy, 0);
        end
        reset = 1'b1;
        drain("after_rst", 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
